// File: rtl/mul_add_pkg.sv
// Shared definitions for the sequential multiply-accumulate unit and the
// divide units that sit on the same operand buses.
package mul_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_add_state_e;

  localparam int unsigned WID_DEFAULT = 128;

  // Width needed to hold the iteration count WID down to 0.
  function automatic int unsigned cnt_width(input int unsigned wid);
    return $clog2(wid + 1);
  endfunction

endpackage

// File: rtl/mul_add_step.sv
// One shift-and-add iteration: conditionally add the shifted multiplicand,
// then advance multiplicand and multiplier by one bit.
module mul_add_step #(
  parameter int unsigned WID = 128
) (
  input  logic [2*WID-1:0] acc_i,
  input  logic [2*WID-1:0] breg_i,
  input  logic [WID-1:0]   qreg_i,
  output logic [2*WID-1:0] acc_o,
  output logic [2*WID-1:0] breg_o,
  output logic [WID-1:0]   qreg_o
);

  always_comb begin
    acc_o  = acc_i;
    if (qreg_i[0]) begin
      acc_o = acc_i + breg_i;
    end
    breg_o = breg_i << 1;
    qreg_o = qreg_i >> 1;
  end

endmodule

// File: rtl/mul_add_seq.sv
// Sequential multiply-accumulate p = b*q + r, one multiplier bit per enabled
// cycle, with the ld/ce/done handshake shared with the divide units.
module mul_add_seq
  import mul_add_pkg::*;
#(
  parameter int unsigned WID = WID_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             ld,
  input  logic [WID-1:0]   b,
  input  logic [WID-1:0]   q,
  input  logic [WID-1:0]   r,
  output logic [2*WID-1:0] p,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = cnt_width(WID);
  localparam logic [CW-1:0] CNT_INIT = CW'(WID);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  mul_add_state_e state_q, state_d;
  logic [2*WID-1:0] breg_q, breg_d;
  logic [WID-1:0]   qreg_q, qreg_d;
  logic [2*WID-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*WID-1:0] p_q, p_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2*WID-1:0] acc_nxt;
  logic [2*WID-1:0] breg_nxt;
  logic [WID-1:0]   qreg_nxt;

  mul_add_step #(
    .WID (WID)
  ) u_step (
    .acc_i  (acc_q),
    .breg_i (breg_q),
    .qreg_i (qreg_q),
    .acc_o  (acc_nxt),
    .breg_o (breg_nxt),
    .qreg_o (qreg_nxt)
  );

  always_comb begin
    state_d = state_q;
    breg_d  = breg_q;
    qreg_d  = qreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = done_q;

    if (ce) begin
      // ld takes priority over the final RUN step, so an abort never
      // publishes a result for the operation it replaces.
      if (ld) begin
        breg_d  = (2*WID)'(b);
        qreg_d  = q;
        acc_d   = (2*WID)'(r);
        cnt_d   = CNT_INIT;
        state_d = RUN;
        busy_d  = 1'b1;
        done_d  = 1'b0;
      end else begin
        unique case (state_q)
          RUN: begin
            acc_d  = acc_nxt;
            breg_d = breg_nxt;
            qreg_d = qreg_nxt;
            cnt_d  = cnt_q - CNT_LAST;
            if (cnt_q == CNT_LAST) begin
              p_d     = acc_nxt;
              ovf_d   = |acc_nxt[2*WID-1:WID];
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
          IDLE, DONE: begin
            state_d = state_q;
          end
          default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      breg_q  <= '0;
      qreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      breg_q  <= breg_d;
      qreg_q  <= qreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign p    = p_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mul_add_seq.sv
// Directed-vector bench for mul_add_seq at WID=32.
module tb_mul_add_seq;

  localparam int unsigned W = 32;

  logic           clk;
  logic           rst;
  logic           ce;
  logic           ld;
  logic [W-1:0]   b;
  logic [W-1:0]   q;
  logic [W-1:0]   r;
  logic [2*W-1:0] p;
  logic           ovf;
  logic           busy;
  logic           done;

  int n_cmp;
  int n_fail;

  mul_add_seq #(
    .WID (W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .ld   (ld),
    .b    (b),
    .q    (q),
    .r    (r),
    .p    (p),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] bv, input logic [W-1:0] qv, input logic [W-1:0] rv);
    ce = 1'b1;
    ld = 1'b1;
    b  = bv;
    q  = qv;
    r  = rv;
    step();
    ld = 1'b0;
  endtask

  // Bounded wait for done; counts clocks and samples with busy high.
  task automatic run_to_done(input int limit, output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cycles < limit) begin
      if (busy === 1'b1) busy_cnt++;
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ce = 1'b0; ld = 1'b0; b = '0; q = '0; r = '0;
    #2;
    n_cmp++;
    if (p !== 64'd0 || ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: p=%h ovf=%b busy=%b done=%b, want all zero", p, ovf, busy, done);
    end
    step(); step();
    rst = 1'b1;
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  task automatic test_basic();
    int cyc, bcnt;
    load(32'd9, 32'd39, 32'd2);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || p !== 64'd0) begin
      n_fail++;
      $display("FAIL basic_start: busy=%b done=%b p=%0d, want 1/0/0", busy, done, p);
    end
    run_to_done(200, cyc, bcnt);
    n_cmp++;
    if (done !== 1'b1 || cyc !== 32) begin
      n_fail++;
      $display("FAIL basic_latency: done=%b cycles=%0d, want 1/32", done, cyc);
    end
    n_cmp++;
    if (bcnt !== 32 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: busy_cycles=%0d busy=%b, want 32/0", bcnt, busy);
    end
    n_cmp++;
    if (p !== 64'd353 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: p=%0d ovf=%b, want 353/0", p, ovf);
    end
  endtask

  task automatic test_max();
    int cyc, bcnt;
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_cmp++;
    if (p !== 64'd353 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL max_hold_p: p=%0d done=%b, want 353/0", p, done);
    end
    run_to_done(200, cyc, bcnt);
    n_cmp++;
    if (done !== 1'b1 || p !== 64'hFFFF_FFFF_0000_0000 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL max_result: done=%b p=%h ovf=%b, want 1/ffffffff00000000/1", done, p, ovf);
    end
  endtask

  task automatic test_zero_and_back_to_back();
    int cyc, bcnt;
    load(32'd2534, 32'd0, 32'd100);
    run_to_done(200, cyc, bcnt);
    n_cmp++;
    if (done !== 1'b1 || cyc !== 32 || p !== 64'd100 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_q: done=%b cycles=%0d p=%0d ovf=%b, want 1/32/100/0", done, cyc, p, ovf);
    end
    load(32'd0, 32'd5, 32'd0);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1 || p !== 64'd100) begin
      n_fail++;
      $display("FAIL b2b_start: done=%b busy=%b p=%0d, want 0/1/100", done, busy, p);
    end
    run_to_done(200, cyc, bcnt);
    n_cmp++;
    if (done !== 1'b1 || cyc !== 32 || p !== 64'd0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_result: done=%b cycles=%0d p=%0d ovf=%b, want 1/32/0/0", done, cyc, p, ovf);
    end
  endtask

  task automatic test_abort();
    int cyc, bcnt, seen;
    seen = 0;
    load(32'd10, 32'd7, 32'd3);
    for (int i = 0; i < 9; i++) begin
      if (done === 1'b1) seen++;
      step();
    end
    load(32'd1000, 32'd4, 32'd5);
    run_to_done(200, cyc, bcnt);
    n_cmp++;
    if (seen !== 0 || done !== 1'b1 || cyc !== 32 || p !== 64'd4005) begin
      n_fail++;
      $display("FAIL abort: early_done=%0d done=%b cycles=%0d p=%0d, want 0/1/32/4005", seen, done, cyc, p);
    end
  endtask

  task automatic test_ld_on_final();
    int cyc, bcnt;
    load(32'd2, 32'd3, 32'd0);
    for (int i = 0; i < 31; i++) step();
    // The next edge would be the final iteration; ld must win.
    ld = 1'b1; b = 32'd7; q = 32'd5; r = 32'd1;
    step();
    ld = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1 || p !== 64'd4005) begin
      n_fail++;
      $display("FAIL ld_final_edge: done=%b busy=%b p=%0d, want 0/1/4005", done, busy, p);
    end
    run_to_done(200, cyc, bcnt);
    n_cmp++;
    if (done !== 1'b1 || cyc !== 32 || p !== 64'd36) begin
      n_fail++;
      $display("FAIL ld_final_result: done=%b cycles=%0d p=%0d, want 1/32/36", done, cyc, p);
    end
  endtask

  task automatic test_ce_toggle();
    int clocks, en_edges;
    clocks = 0;
    en_edges = 0;
    load(32'd3, 32'd11, 32'd1);
    while (done !== 1'b1 && clocks < 200) begin
      ce = clocks[0];
      // ld on a disabled cycle must be ignored.
      if (clocks == 0) begin
        ld = 1'b1; b = 32'hDEAD; q = 32'hBEEF; r = 32'h1234;
      end else begin
        ld = 1'b0;
      end
      step();
      if (ce === 1'b1) en_edges++;
      clocks++;
    end
    ce = 1'b1;
    ld = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || en_edges !== 32 || clocks !== 64) begin
      n_fail++;
      $display("FAIL ce_latency: done=%b enabled=%0d clocks=%0d, want 1/32/64", done, en_edges, clocks);
    end
    n_cmp++;
    if (p !== 64'd34 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ce_result: p=%0d ovf=%b, want 34/0", p, ovf);
    end
  endtask

  task automatic test_async_reset();
    int cyc, bcnt;
    load(32'd5, 32'd6, 32'd7);
    for (int i = 0; i < 14; i++) step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (p !== 64'd0 || ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: p=%0d ovf=%b busy=%b done=%b, want 0/0/0/0", p, ovf, busy, done);
    end
    step();
    rst = 1'b1;
    step(); step();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b done=%b, want 0/0", busy, done);
    end
    load(32'd100, 32'd3, 32'd0);
    run_to_done(200, cyc, bcnt);
    n_cmp++;
    if (done !== 1'b1 || cyc !== 32 || p !== 64'd300) begin
      n_fail++;
      $display("FAIL post_reset_result: done=%b cycles=%0d p=%0d, want 1/32/300", done, cyc, p);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero_and_back_to_back();
    test_abort();
    test_ld_on_final();
    test_ce_toggle();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_add_seq.md
# mul_add_seq

Sequential multiply-accumulate unit computing p = b*q + r, one multiplier bit per enabled cycle. It is the recombining counterpart of the divider path: it takes a quotient, divisor and remainder and rebuilds the dividend. It serves as the general multiply engine and as the in-system checker for divide results (p must equal the original dividend, and ovf must be 0). It sits beside the divide units on the same operand buses and uses the same ld/ce/done handshake.

## Interface
- WID, 128, operand width; b, q and r are WID bits, p is 2*WID bits.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- ce  input  1  clock enable; when 0, all state and outputs hold and ld is ignored.
- ld  input  1  start pulse; sampled only when ce=1.
- b  input  WID  multiplicand (divisor when checking a divide).
- q  input  WID  multiplier (quotient when checking a divide).
- r  input  WID  addend (remainder when checking a divide), zero-extended.
- p  output  2*WID  result register; updated only on completion.
- ovf  output  1  p[2*WID-1:WID] != 0; registered with p.
- busy  output  1  operation in progress.
- done  output  1  result valid; held until the next accepted ld or reset.

## Operation
- States: IDLE, RUN, DONE. Encoded in a 2-bit register.
- Internal registers: breg (2*WID, shifted multiplicand), qreg (WID), acc (2*WID), cnt (counts WID down to 0).
- Accepted ld (ce=1), in any state:
  - breg = {0,b}, qreg = q, acc = {0,r}, cnt = WID.
  - State goes to RUN, busy=1, done=0.
  - p and ovf keep their previous values.
- RUN, each ce=1 edge:
  - If qreg[0]=1, acc += breg.
  - breg <<= 1, qreg >>= 1, cnt -= 1.
  - On the edge where cnt goes 1 to 0, the final acc (including that step's add) loads p, and ovf is set from the upper half.
  - On that same edge: busy=0, done=1, state goes to DONE.
- DONE: holds p, ovf and done=1 until the next accepted ld. IDLE and DONE both accept ld.
- Arithmetic: the maximum result is (2^WID-1)^2 + (2^WID-1) = 2^(2*WID) - 2^WID, so a 2*WID accumulator never wraps. No carry-out bit is needed.
- ld during RUN aborts the current operation and restarts it with the new operands. No done pulse is produced for the aborted operation.
- ld together with the final RUN step: ld wins. p is not updated, done stays 0, and the new operation starts.
- ce=0 during RUN stretches the latency. No iteration is lost or duplicated.
- rst asserted at any time, including mid-operation: state=IDLE, all registers cleared, p=0, ovf=0, busy=0, done=0.

## Timing
- Reset values: p=0, ovf=0, busy=0, done=0, state=IDLE.
- Latency: ld accepted at edge 0; iterations occur at edges 1..WID; p, ovf and done are valid after edge WID.
  - With ce held high, that is exactly WID cycles after the ld edge.
  - Latency is fixed and independent of operand values. There is no early exit for q=0.
- busy is high from edge 0 through edge WID-1, and low after edge WID.
- Back-to-back operation: ld may be asserted in the same cycle done first reads 1. The next result follows WID cycles later.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package mul_add_pkg:
  - state enum (IDLE, RUN, DONE);
  - default WID constant;
  - cnt width function ($clog2(WID+1)).
- The divide units import the same package for WID.
- One sub-module is natural: mul_add_step, the combinational single-iteration datapath. It takes (acc, breg, qreg) and returns their next values. The top level holds the FSM, counter and registers.

## Test plan
- WID=32, b=9, q=39, r=2, ld with ce=1: p=353, ovf=0. done rises exactly 32 cycles after ld, and busy is high for 32 cycles.
- WID=32, b=q=r=0xFFFFFFFF: p=0xFFFFFFFF_00000000, ovf=1.
- WID=32, b=2534, q=0, r=100: p=100, ovf=0, latency still 32 cycles. A following ld of b=0, q=5, r=0 gives p=0.
- ld of b=10, q=7, r=3, then a second ld of b=1000, q=4, r=5 at cycle 10: there is no done pulse for the first operation. p=4005 is valid 32 cycles after the second ld.
- ce toggled 1/0 every cycle during b=3, q=11, r=1: p=34, and done arrives after 32 enabled edges (about 64 clocks).
- rst asserted at cycle 15 of an operation: p=0, busy=0, done=0 immediately, without waiting for a clock. After release, a new ld of b=100, q=3, r=0 gives p=300.
